// File: rtl/divider_fp.sv
// Sequential IEEE-754 single-precision divider (a_operand / b_operand), radix-2 restoring, 27-cycle latency.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient mantissa is truncated.
module divider_fp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow,
    output logic        DivByZero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_ROUND
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sign_q, sign_d;
    logic [9:0]  exp_q, exp_d;
    logic [23:0] mb_q, mb_d;
    logic [24:0] rem_q, rem_d;
    logic [24:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        exc_q, exc_d;
    logic        dbz_q, dbz_d;
    logic        zdiv_q, zdiv_d;

    logic        done_q, done_d;
    logic [31:0] res_q, res_d;
    logic        exc_flag_q, exc_flag_d;
    logic        ovf_flag_q, ovf_flag_d;
    logic        unf_flag_q, unf_flag_d;
    logic        dbz_flag_q, dbz_flag_d;

    logic [25:0] trial;
    logic        qbit;
    logic [24:0] rem_keep;

    logic [22:0] mant_sel;
    logic [9:0]  e_adj;
    logic [9:0]  e_rnd;
    logic [23:0] mant_inc;
    logic        rnd_up;
    logic        ovf_c;
    logic        unf_c;
`ifdef FP_DIV_ROUND_EN
    logic        guard;
    logic        sticky;
`endif

    logic [7:0]  a_exp, b_exp;
    logic        a_zero, b_zero, a_inf, b_inf;

    assign a_exp  = a_q[30:23];
    assign b_exp  = b_q[30:23];
    assign a_zero = (a_exp == 8'h00);
    assign b_zero = (b_exp == 8'h00);
    assign a_inf  = (a_exp == 8'hFF);
    assign b_inf  = (b_exp == 8'hFF);

    // One restoring step: compare against the divisor, keep the difference when non-negative.
    always_comb begin
        trial    = {1'b0, rem_q} - {2'b0, mb_q};
        qbit     = ~trial[25];
        rem_keep = qbit ? trial[24:0] : rem_q;
    end

    // DIV runs 25 steps; ROUND performs the 26th step here so the full quotient is
    // {quo_q, qbit} and the final remainder is rem_keep, keeping done at 27 edges.
    always_comb begin
        if (quo_q[24]) begin
            mant_sel = quo_q[23:1];
            e_adj    = exp_q;
        end else begin
            mant_sel = quo_q[22:0];
            e_adj    = exp_q - 10'd1;
        end
`ifdef FP_DIV_ROUND_EN
        if (quo_q[24]) begin
            guard  = quo_q[0];
            sticky = qbit | (rem_keep != '0);
        end else begin
            guard  = qbit;
            sticky = (rem_keep != '0);
        end
        rnd_up = guard & (sticky | mant_sel[0]);
`else
        rnd_up = 1'b0;
`endif
        mant_inc = {1'b0, mant_sel} + {23'd0, rnd_up};
        e_rnd    = mant_inc[23] ? e_adj + 10'd1 : e_adj;
        ovf_c    = ($signed(e_rnd) >= 10'sd255);
        unf_c    = ($signed(e_rnd) <= 10'sd0);
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mb_d       = mb_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        exc_d      = exc_q;
        dbz_d      = dbz_q;
        zdiv_d     = zdiv_q;
        done_d     = 1'b0;
        res_d      = res_q;
        exc_flag_d = exc_flag_q;
        ovf_flag_d = ovf_flag_q;
        unf_flag_d = unf_flag_q;
        dbz_flag_d = dbz_flag_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_operand;
                    b_d     = b_operand;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sign_d  = a_q[31] ^ b_q[31];
                exp_d   = {2'b0, a_exp} - {2'b0, b_exp} + 10'd127;
                mb_d    = {1'b1, b_q[22:0]};
                rem_d   = {2'b01, a_q[22:0]};
                quo_d   = '0;
                cnt_d   = '0;
                exc_d   = a_inf | b_inf | (a_zero & b_zero);
                dbz_d   = b_zero & ~a_zero & ~a_inf;
                zdiv_d  = a_zero;
                state_d = S_DIV;
            end
            S_DIV: begin
                rem_d = rem_keep << 1;
                quo_d = {quo_q[23:0], qbit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd24) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                done_d     = 1'b1;
                state_d    = S_IDLE;
                exc_flag_d = 1'b0;
                ovf_flag_d = 1'b0;
                unf_flag_d = 1'b0;
                dbz_flag_d = 1'b0;
                if (exc_q) begin
                    res_d      = '0;
                    exc_flag_d = 1'b1;
                end else if (dbz_q) begin
                    res_d      = {sign_q, 8'hFF, 23'd0};
                    dbz_flag_d = 1'b1;
                end else if (zdiv_q) begin
                    res_d      = {sign_q, 31'd0};
                end else if (ovf_c) begin
                    res_d      = {sign_q, 8'hFF, 23'd0};
                    ovf_flag_d = 1'b1;
                end else if (unf_c) begin
                    res_d      = {sign_q, 31'd0};
                    unf_flag_d = 1'b1;
                end else begin
                    res_d      = {sign_q, e_rnd[7:0], mant_inc[22:0]};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mb_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            exc_q      <= 1'b0;
            dbz_q      <= 1'b0;
            zdiv_q     <= 1'b0;
            done_q     <= 1'b0;
            res_q      <= '0;
            exc_flag_q <= 1'b0;
            ovf_flag_q <= 1'b0;
            unf_flag_q <= 1'b0;
            dbz_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mb_q       <= mb_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            exc_q      <= exc_d;
            dbz_q      <= dbz_d;
            zdiv_q     <= zdiv_d;
            done_q     <= done_d;
            res_q      <= res_d;
            exc_flag_q <= exc_flag_d;
            ovf_flag_q <= ovf_flag_d;
            unf_flag_q <= unf_flag_d;
            dbz_flag_q <= dbz_flag_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = res_q;
    assign Exception = exc_flag_q;
    assign Overflow  = ovf_flag_q;
    assign Underflow = unf_flag_q;
    assign DivByZero = dbz_flag_q;

endmodule

// File: tb/tb_divider_fp.sv
// Self-checking bench for divider_fp: integer-arithmetic reference model plus directed literal vectors.
// Honours FP_DIV_ROUND_EN the same way as the design.
module tb_divider_fp;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
        logic        ovf;
        logic        unf;
        logic        dbz;
    } out_t;

`ifdef FP_DIV_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        Exception;
    logic        Overflow;
    logic        Underflow;
    logic        DivByZero;

    int errors = 0;
    int checks = 0;

    divider_fp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .Exception (Exception),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .DivByZero (DivByZero)
    );

    always #5 clk = ~clk;

    // Quotient from exact integer division: q = floor(ma * 2^25 / mb), r = remainder.
    function automatic out_t ref_div(input logic [31:0] a, input logic [31:0] b);
        out_t            o;
        int              ea, eb, e;
        logic            s;
        longint unsigned ma, mb, num, q, r, mant;
        bit              g, st;
        o  = '0;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) begin
            o.exc = 1'b1;
            return o;
        end
        if (eb == 0) begin
            o.dbz = 1'b1;
            o.res = {s, 8'hFF, 23'd0};
            return o;
        end
        if (ea == 0) begin
            o.res = {s, 31'd0};
            return o;
        end
        ma  = 64'd8388608 + longint'(a[22:0]);
        mb  = 64'd8388608 + longint'(b[22:0]);
        num = ma * 64'd33554432;
        q   = num / mb;
        r   = num % mb;
        e   = ea - eb + 127;
        if (q >= 64'd33554432) begin
            mant = (q / 4) % 64'd8388608;
            g    = ((q / 2) % 2) != 0;
            st   = ((q % 2) != 0) || (r != 0);
        end else begin
            e    = e - 1;
            mant = (q / 2) % 64'd8388608;
            g    = (q % 2) != 0;
            st   = (r != 0);
        end
        if (ROUND && g && (st || (mant % 2) == 1)) mant = mant + 1;
        if (mant == 64'd8388608) begin
            mant = 0;
            e    = e + 1;
        end
        if (e >= 255) begin
            o.ovf = 1'b1;
            o.res = {s, 8'hFF, 23'd0};
        end else if (e <= 0) begin
            o.unf = 1'b1;
            o.res = {s, 31'd0};
        end else begin
            o.res = {s, e[7:0], mant[22:0]};
        end
        return o;
    endfunction

    // Cycle-level expectation: accept in idle, done 27 edges later, outputs held otherwise.
    bit   m_busy   = 1'b0;
    int   m_cnt    = 0;
    bit   exp_done = 1'b0;
    out_t exp_o    = '0;
    out_t pend     = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_cnt    = 0;
            exp_done = 1'b0;
            exp_o    = '0;
        end else if (!m_busy) begin
            exp_done = 1'b0;
            if (start) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                pend   = ref_div(a_operand, b_operand);
            end
        end else begin
            m_cnt    = m_cnt + 1;
            exp_done = (m_cnt == 27);
            if (exp_done) begin
                m_busy = 1'b0;
                exp_o  = pend;
            end
        end
        #1;
        checks = checks + 1;
        if ({busy, done, result, Exception, Overflow, Underflow, DivByZero} !== {m_busy, exp_done, exp_o}) begin
            errors = errors + 1;
            $display("FAIL cycle_outputs @%0t: got busy=%b done=%b res=%h flags=%b%b%b%b, expected busy=%b done=%b res=%h flags=%b%b%b%b",
                     $time, busy, done, result, Exception, Overflow, Underflow, DivByZero,
                     m_busy, exp_done, exp_o.res, exp_o.exc, exp_o.ovf, exp_o.unf, exp_o.dbz);
        end
    end

    task automatic check_model(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [35:0] want);
        out_t got;
        got    = ref_div(a, b);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL model_%s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] want_res, input logic [3:0] want_flags);
        checks = checks + 1;
        if ({result, Exception, Overflow, Underflow, DivByZero} !== {want_res, want_flags}) begin
            errors = errors + 1;
            $display("FAIL %s: got res=%h flags=%b%b%b%b expected res=%h flags=%b",
                     name, result, Exception, Overflow, Underflow, DivByZero, want_res, want_flags);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int gap, input bit poke);
        start     = 1'b1;
        a_operand = a;
        b_operand = b;
        @(negedge clk);
        start     = 1'b0;
        a_operand = $urandom;
        b_operand = $urandom;
        for (int i = 0; i < 27 + gap; i++) begin
            start = (poke && i == 4);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 9))
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 8));
            3:       e = 8'($urandom_range(247, 254));
            default: e = 8'($urandom_range(90, 165));
        endcase
        case ($urandom_range(0, 3))
            0:       m = '0;
            1:       m = '1;
            default: m = 23'($urandom);
        endcase
        return {1'($urandom), e, m};
    endfunction

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        a_operand = '0;
        b_operand = '0;

        check_model("6div2", 32'h40C00000, 32'h40000000, {32'h40400000, 4'b0000});
        check_model("1div3", 32'h3F800000, 32'h40400000,
                    {(ROUND ? 32'h3EAAAAAB : 32'h3EAAAAAA), 4'b0000});
        check_model("ovf", 32'h7F000000, 32'h3E800000, {32'h7F800000, 4'b0100});
        check_model("unf", 32'h00800000, 32'h40000000, {32'h00000000, 4'b0010});
        check_model("dbz", 32'hBF800000, 32'h00000000, {32'hFF800000, 4'b0001});

        repeat (3) @(negedge clk);
        check_lit("reset_state", 32'h0, 4'b0000);
        rst_n = 1'b1;

        issue(32'h40C00000, 32'h40000000, 0, 1'b0);
        check_lit("6div2", 32'h40400000, 4'b0000);
        issue(32'h3F800000, 32'h40400000, 1, 1'b0);
        check_lit("1div3", (ROUND ? 32'h3EAAAAAB : 32'h3EAAAAAA), 4'b0000);
        issue(32'hBF800000, 32'h00000000, 0, 1'b0);
        check_lit("div_by_zero", 32'hFF800000, 4'b0001);
        issue(32'h00000000, 32'h00000000, 0, 1'b0);
        check_lit("zero_div_zero", 32'h00000000, 4'b1000);
        issue(32'h7F000000, 32'h3E800000, 0, 1'b0);
        check_lit("overflow", 32'h7F800000, 4'b0100);
        issue(32'h00800000, 32'h40000000, 2, 1'b0);
        check_lit("underflow", 32'h00000000, 4'b0010);
        issue(32'h80000000, 32'h40000000, 0, 1'b0);
        check_lit("neg_zero_dividend", 32'h80000000, 4'b0000);

        issue(32'h40C00000, 32'h40000000, 0, 1'b1);
        check_lit("start_while_busy", 32'h40400000, 4'b0000);

        start     = 1'b1;
        a_operand = 32'h3F800000;
        b_operand = 32'h40400000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_lit("abort_reset", 32'h0, 4'b0000);
        repeat (30) @(negedge clk);
        issue(32'hBF800000, 32'h3F000000, 0, 1'b0);
        check_lit("after_reset", 32'hC0000000, 4'b0000);

        for (int n = 0; n < 250; n++) begin
            issue(rnd_fp(), rnd_fp(), int'($urandom_range(0, 3)) - 0, ($urandom_range(0, 4) == 0));
        end
        issue(32'h3FFFFFFF, 32'h3F800001, 0, 1'b0);
        issue(32'h3F800000, 32'h3FFFFFFF, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
